// File: rtl/camera_downscale_2x.sv
// 2x2 box-average decimator for an RGB565 pixel stream.
// Horizontal pair sums from even rows wait in a line buffer and are combined with the matching odd-row pair.
module camera_downscale_2x #(
  parameter int IN_WIDTH  = 640,
  parameter int IN_HEIGHT = 480,
  parameter int OUT_WIDTH = IN_WIDTH / 2,
  parameter int ADDR_W    = 17
) (
  input  logic              p_clock,
  input  logic              reset,
  input  logic [15:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  output logic [15:0]       out_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_frame_done
);

  localparam int COL_W = $clog2(IN_WIDTH);
  localparam int IDX_W = COL_W - 1;
  localparam int ROW_W = $clog2(IN_HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(IN_HEIGHT);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       latch_q, latch_d;
  logic [15:0]       outData_q, outData_d;
  logic              outValid_q, outValid_d;
  logic [ADDR_W-1:0] outAddr_q, outAddr_d;
  logic              frameDone_q;
  logic [18:0]       rdData_q;

  logic [18:0] lineBuf [OUT_WIDTH];

  logic             accept;
  logic             oddCol;
  logic             oddRow;
  logic             bufWrite;
  logic             bufRead;
  logic [IDX_W-1:0] pairIdx;
  logic [5:0]       rPair;
  logic [6:0]       gPair;
  logic [5:0]       bPair;
  logic [18:0]      pairSum;
  logic [6:0]       rTot;
  logic [7:0]       gTot;
  logic [6:0]       bTot;
  logic [15:0]      blockAvg;
  logic [5:0]       unusedLowBits;

  // Pixels past the last row are ignored until frame_done; frame_done beats a coincident pixel.
  assign accept   = pixel_valid && !frame_done && (row_q != ROW_END);
  assign oddCol   = col_q[0];
  assign oddRow   = row_q[0];
  assign pairIdx  = col_q[COL_W-1:1];
  assign bufWrite = accept && !oddRow && oddCol;
  assign bufRead  = accept && oddRow && !oddCol;

  assign rPair   = {1'b0, latch_q[15:11]} + {1'b0, pixel_data[15:11]};
  assign gPair   = {1'b0, latch_q[10:5]}  + {1'b0, pixel_data[10:5]};
  assign bPair   = {1'b0, latch_q[4:0]}   + {1'b0, pixel_data[4:0]};
  assign pairSum = {rPair, gPair, bPair};

  assign rTot = {1'b0, rPair} + {1'b0, rdData_q[18:13]};
  assign gTot = {1'b0, gPair} + {1'b0, rdData_q[12:6]};
  assign bTot = {1'b0, bPair} + {1'b0, rdData_q[5:0]};

  // Divide-by-four truncates; the dropped low bits are intentionally discarded.
  assign blockAvg      = {rTot[6:2], gTot[7:2], bTot[6:2]};
  assign unusedLowBits = {rTot[1:0], gTot[1:0], bTot[1:0]};

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    latch_d    = latch_q;
    outData_d  = outData_q;
    outValid_d = 1'b0;
    outAddr_d  = outAddr_q;
    if (frame_done) begin
      col_d   = '0;
      row_d   = '0;
      addr_d  = '0;
      latch_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      if (!oddCol) begin
        latch_d = pixel_data;
      end
      if (oddRow && oddCol) begin
        outData_d  = blockAvg;
        outValid_d = 1'b1;
        outAddr_d  = addr_q;
        addr_d     = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge p_clock) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      latch_q     <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outAddr_q   <= '0;
      frameDone_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      latch_q     <= latch_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      outAddr_q   <= outAddr_d;
      frameDone_q <= frame_done;
    end
  end

  // Read is issued on the even odd-row pixel so the sum is ready however long the odd pixel takes.
  always_ff @(posedge p_clock) begin
    if (bufWrite) begin
      lineBuf[pairIdx] <= pairSum;
    end
    if (bufRead) begin
      rdData_q <= lineBuf[pairIdx];
    end
  end

  assign out_data       = outData_q;
  assign out_valid      = outValid_q;
  assign out_addr       = outAddr_q;
  assign out_frame_done = frameDone_q;

endmodule
